// File: rtl/ahb_bus_arbiter_if.sv
// Bus-side signal bundle between AHB masters and the shared-path arbiter.
// The "master" modport is the requesting side, "slave" is the arbiter.
interface ahb_bus_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int MW = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
);
    logic [NUM_MASTERS-1:0] hbusreq;
    logic [NUM_MASTERS-1:0] hlock;
    logic [1:0]             htrans;
    logic [2:0]             hburst;
    logic                   hready;
    logic [NUM_MASTERS-1:0] hgrant;
    logic [MW-1:0]          hmaster;
    logic                   hmastlock;

    modport master (
        output hbusreq, hlock, htrans, hburst, hready,
        input  hgrant, hmaster, hmastlock
    );

    modport slave (
        input  hbusreq, hlock, htrans, hburst, hready,
        output hgrant, hmaster, hmastlock
    );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter with burst/lock hold and default-master parking.
// Grant pointer is the next owner; hmaster trails it by one accepted cycle.
module ahb_bus_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int MW             = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic hclk,
    input  logic hresetn,
    ahb_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ARB    = 2'd0,
        BURST  = 2'd1,
        LOCKED = 2'd2
    } state_e;

    localparam logic [MW-1:0] DEF = MW'(DEFAULT_MASTER);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [MW-1:0] gnt_q, gnt_d;
    logic [MW-1:0] mst_q;
    logic          lock_q;

    logic [MW-1:0] rr_win;
    logic          found;
    int            idx;
    logic          arb;
    logic          own_lock;
    logic          nonseq;
    logic          seq;
    logic [3:0]    beats;

    assign own_lock = bus.hlock[mst_q];
    assign nonseq   = (bus.htrans == 2'b10);
    assign seq      = (bus.htrans == 2'b11);

    always_comb begin
        unique case (bus.hburst)
            3'd1:    beats = 4'd3;
            3'd2:    beats = 4'd7;
            3'd3:    beats = 4'd15;
            default: beats = 4'd0;
        endcase
    end

    // Search after the current grant holder, holder itself last.
    always_comb begin
        rr_win = DEF;
        found  = 1'b0;
        idx    = 0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            idx = (int'(gnt_q) + i) % NUM_MASTERS;
            if (!found && bus.hbusreq[idx]) begin
                rr_win = MW'(idx);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        arb     = 1'b0;
        unique case (state_q)
            ARB: begin
                if (nonseq && own_lock) begin
                    state_d = LOCKED;
                end else if (nonseq && beats != 4'd0) begin
                    state_d = BURST;
                    cnt_d   = beats;
                end else begin
                    arb = 1'b1;
                end
            end
            BURST: begin
                if (seq) begin
                    if (cnt_q == 4'd1) begin
                        arb     = 1'b1;
                        state_d = ARB;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end else if (!bus.htrans[0]) begin
                    // IDLE or NONSEQ cut the burst short
                    arb     = 1'b1;
                    state_d = ARB;
                    cnt_d   = 4'd0;
                end
            end
            LOCKED: begin
                if (!own_lock) begin
                    arb     = 1'b1;
                    state_d = ARB;
                end
            end
            default: begin
                state_d = ARB;
                cnt_d   = 4'd0;
            end
        endcase
        if (arb) begin
            gnt_d = rr_win;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= ARB;
            cnt_q   <= 4'd0;
            gnt_q   <= DEF;
            mst_q   <= DEF;
            lock_q  <= 1'b0;
        end else if (bus.hready) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            mst_q   <= gnt_q;
            lock_q  <= own_lock & (bus.htrans != 2'b00);
        end
    end

    assign bus.hgrant    = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << gnt_q;
    assign bus.hmaster   = mst_q;
    assign bus.hmastlock = lock_q;
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed and randomized checks of the AHB arbiter against a
// transaction-level model of ownership, bursts and locks.
module tb_ahb_bus_arbiter;
    localparam int N = 4;

    logic hclk;
    logic hresetn;
    int   n_chk;
    int   n_fail;

    ahb_bus_arbiter_if #(.NUM_MASTERS(N), .MW(2)) bus ();

    ahb_bus_arbiter #(
        .NUM_MASTERS(N),
        .MW(2),
        .DEFAULT_MASTER(0)
    ) dut (
        .hclk(hclk),
        .hresetn(hresetn),
        .bus(bus)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // Reference model: who is granted next, who owns now, beats left.
    int   m_own;
    int   m_hm;
    bit   m_lk;
    int   m_left;
    bit   m_locked;

    function automatic int rr_pick(int from, logic [N-1:0] req);
        for (int k = 1; k <= N; k++) begin
            if (req[(from + k) % N]) return (from + k) % N;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_own    = 0;
        m_hm     = 0;
        m_lk     = 1'b0;
        m_left   = 0;
        m_locked = 1'b0;
    endtask

    task automatic model_edge();
        bit ol;
        bit pt;
        if (!hresetn) begin
            model_reset();
            return;
        end
        if (!bus.hready) return;
        ol = bus.hlock[m_hm];
        pt = 1'b0;
        if (m_locked) begin
            if (!ol) begin
                pt       = 1'b1;
                m_locked = 1'b0;
            end
        end else if (m_left > 0) begin
            if (bus.htrans == 2'd3) begin
                if (m_left == 1) pt = 1'b1;
                m_left = m_left - 1;
            end else if (bus.htrans == 2'd0 || bus.htrans == 2'd2) begin
                pt     = 1'b1;
                m_left = 0;
            end
        end else if (bus.htrans == 2'd2 && ol) begin
            m_locked = 1'b1;
        end else if (bus.htrans == 2'd2 && bus.hburst inside {3'd1, 3'd2, 3'd3}) begin
            m_left = (2 << bus.hburst) - 1;
        end else begin
            pt = 1'b1;
        end
        m_lk = ol && (bus.htrans != 2'd0);
        m_hm = m_own;
        if (pt) m_own = rr_pick(m_own, bus.hbusreq);
    endtask

    task automatic cyc();
        @(posedge hclk);
        model_edge();
        #1;
    endtask

    task automatic drive(logic [N-1:0] req, logic [N-1:0] lk,
                         logic [1:0] tr, logic [2:0] bu, logic rdy);
        bus.hbusreq = req;
        bus.hlock   = lk;
        bus.htrans  = tr;
        bus.hburst  = bu;
        bus.hready  = rdy;
    endtask

    task automatic do_reset();
        hresetn = 1'b0;
        model_reset();
        cyc();
        cyc();
        hresetn = 1'b1;
    endtask

    task automatic test_reset();
        drive(4'b0110, 4'b0000, 2'd0, 3'd0, 1'b1);
        hresetn = 1'b0;
        model_reset();
        cyc();
        cyc();
        n_chk++;
        if (bus.hgrant !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_grant got %b want 0001", bus.hgrant);
        end
        n_chk++;
        if (bus.hmaster !== 2'd0 || bus.hmastlock !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_master got %0d/%b want 0/0",
                     bus.hmaster, bus.hmastlock);
        end
        hresetn = 1'b1;
        cyc();
        n_chk++;
        if (bus.hgrant !== 4'b0010 || bus.hmaster !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_first_grant got %b/%0d want 0010/0",
                     bus.hgrant, bus.hmaster);
        end
        cyc();
        n_chk++;
        if (bus.hmaster !== 2'd1) begin
            n_fail++;
            $display("FAIL reset_hmaster_lag got %0d want 1", bus.hmaster);
        end
    endtask

    task automatic test_rotate();
        logic [3:0] eg [6] = '{4'b0010, 4'b0100, 4'b1000,
                               4'b0010, 4'b0100, 4'b1000};
        logic [1:0] em [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2};
        do_reset();
        drive(4'b1110, 4'b0000, 2'd2, 3'd0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cyc();
            n_chk++;
            if (bus.hgrant !== eg[i] || bus.hmaster !== em[i]) begin
                n_fail++;
                $display("FAIL rotate[%0d] got %b/%0d want %b/%0d",
                         i, bus.hgrant, bus.hmaster, eg[i], em[i]);
            end
        end
    endtask

    task automatic own_master(logic [N-1:0] req);
        do_reset();
        drive(req, 4'b0000, 2'd0, 3'd0, 1'b1);
        cyc();
        cyc();
    endtask

    task automatic test_burst(bit stall);
        own_master(4'b0100);
        drive(4'b0101, 4'b0000, 2'd2, 3'd1, 1'b1);
        cyc();
        bus.htrans = 2'd3;
        cyc();
        if (stall) begin
            bus.hready = 1'b0;
            for (int i = 0; i < 3; i++) begin
                cyc();
                n_chk++;
                if (bus.hgrant !== 4'b0100 || bus.hmaster !== 2'd2) begin
                    n_fail++;
                    $display("FAIL stall_hold[%0d] got %b/%0d want 0100/2",
                             i, bus.hgrant, bus.hmaster);
                end
            end
            bus.hready = 1'b1;
            bus.htrans = 2'd1;
            cyc();
            bus.htrans = 2'd3;
        end
        cyc();
        n_chk++;
        if (bus.hgrant !== 4'b0100 || bus.hmaster !== 2'd2) begin
            n_fail++;
            $display("FAIL burst_hold got %b/%0d want 0100/2",
                     bus.hgrant, bus.hmaster);
        end
        cyc();
        n_chk++;
        if (bus.hgrant !== 4'b0001 || bus.hmaster !== 2'd2) begin
            n_fail++;
            $display("FAIL burst_handover got %b/%0d want 0001/2",
                     bus.hgrant, bus.hmaster);
        end
        bus.htrans = 2'd0;
        cyc();
        n_chk++;
        if (bus.hmaster !== 2'd0) begin
            n_fail++;
            $display("FAIL burst_hmaster got %0d want 0", bus.hmaster);
        end
    endtask

    task automatic test_lock();
        bit bad;
        own_master(4'b0010);
        drive(4'b1010, 4'b0010, 2'd2, 3'd1, 1'b1);
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (bus.hgrant !== 4'b0010 || bus.hmastlock !== 1'b1) bad = 1'b1;
            bus.htrans = (i == 3) ? 2'd2 : 2'd3;
        end
        n_chk++;
        if (bad) begin
            n_fail++;
            $display("FAIL lock_hold got %b/%b want 0010/1",
                     bus.hgrant, bus.hmastlock);
        end
        drive(4'b1010, 4'b0000, 2'd0, 3'd0, 1'b1);
        cyc();
        n_chk++;
        if (bus.hgrant !== 4'b1000 || bus.hmastlock !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_release got %b/%b want 1000/0",
                     bus.hgrant, bus.hmastlock);
        end
    endtask

    task automatic test_park();
        own_master(4'b1110);
        cyc();
        drive(4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1);
        cyc();
        n_chk++;
        if (bus.hgrant !== 4'b0001) begin
            n_fail++;
            $display("FAIL park got %b want 0001", bus.hgrant);
        end
        own_master(4'b1000);
        drive(4'b1001, 4'b1000, 2'd2, 3'd2, 1'b1);
        cyc();
        bus.htrans = 2'd3;
        cyc();
        cyc();
        #2;
        hresetn = 1'b0;
        #1;
        model_reset();
        n_chk++;
        if (bus.hgrant !== 4'b0001 || bus.hmaster !== 2'd0 ||
            bus.hmastlock !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset got %b/%0d/%b want 0001/0/0",
                     bus.hgrant, bus.hmaster, bus.hmastlock);
        end
        #2;
        hresetn = 1'b1;
        drive(4'b1000, 4'b0000, 2'd3, 3'd0, 1'b1);
        cyc();
        n_chk++;
        if (bus.hgrant !== 4'b1000) begin
            n_fail++;
            $display("FAIL post_reset_arb got %b want 1000", bus.hgrant);
        end
    endtask

    task automatic test_random();
        logic [3:0] eg;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bus.hbusreq = 4'($urandom);
            bus.hlock   = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0;
            bus.htrans  = 2'($urandom);
            bus.hburst  = 3'($urandom);
            bus.hready  = ($urandom_range(0, 3) != 0);
            cyc();
            eg = 4'b0001 << m_own;
            n_chk++;
            if (bus.hgrant !== eg || bus.hmaster !== 2'(m_hm) ||
                bus.hmastlock !== m_lk) begin
                n_fail++;
                $display("FAIL random[%0d] got %b/%0d/%b want %b/%0d/%b",
                         i, bus.hgrant, bus.hmaster, bus.hmastlock,
                         eg, m_hm, m_lk);
            end
            n_chk++;
            if (!$onehot(bus.hgrant)) begin
                n_fail++;
                $display("FAIL onehot[%0d] got %b want one-hot", i, bus.hgrant);
            end
        end
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        hresetn = 1'b0;
        drive(4'b0, 4'b0, 2'd0, 3'd0, 1'b1);
        model_reset();
        test_reset();
        test_rotate();
        test_burst(1'b0);
        test_burst(1'b1);
        test_lock();
        test_park();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
